patch_serializer: RTL

PATCH_SERIALIZER -- requirements
Module: patch_serializer

---
 rtl/dnd_pkg.sv | 29 ++
 rtl/patch_serializer_if.sv | 33 +++
 rtl/age_quant.sv | 44 ++++
 rtl/patch_serializer.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/dnd_pkg.sv
// Shared definitions for the patch datapath (patch_serializer, mlp_serial).
// Holds the patch geometry, the timestamp/magnitude widths, the polarity
// encodings and the serializer state type.
package dnd_pkg;

  localparam int N_PIX   = 49;  // pixels per 7x7 patch
  localparam int P       = 2;   // pixels per beat
  localparam int W_X     = 4;   // age magnitude width
  localparam int W_T     = 16;  // timestamp width
  localparam int SHIFT   = 8;   // log2 of timestamp ticks per magnitude step
  localparam int MIN_GAP = 4;   // idle cycles forced after each patch

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  localparam int N_BEATS = ceil_div(N_PIX, P);

  localparam logic [1:0] POL_NONE = 2'b00;
  localparam logic [1:0] POL_ON   = 2'b01;
  localparam logic [1:0] POL_OFF  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_STREAM = 2'b01,
    ST_HOLD   = 2'b10
  } ser_state_e;

endpackage

// File: rtl/patch_serializer_if.sv
// Patch-in / beat-out bus of patch_serializer.
//   s_vld/s_rdy      : patch handshake
//   s_ts_now         : timestamp of the triggering event
//   s_ts, s_pol      : per-pixel last timestamp and stored polarity
//   m_vld/m_mag/m_pol: beat stream towards mlp_serial (no backpressure)
// Modport slave is the serializer's view, master the patch source / sink.
interface patch_serializer_if
  import dnd_pkg::*;
#(
  parameter int N_PIX = dnd_pkg::N_PIX,
  parameter int P     = dnd_pkg::P,
  parameter int W_X   = dnd_pkg::W_X,
  parameter int W_T   = dnd_pkg::W_T
);
  logic                   s_vld;
  logic                   s_rdy;
  logic [W_T-1:0]         s_ts_now;
  logic [N_PIX*W_T-1:0]   s_ts;
  logic [N_PIX*2-1:0]     s_pol;
  logic                   m_vld;
  logic [P*W_X-1:0]       m_mag;
  logic [P*2-1:0]         m_pol;

  modport slave (
    input  s_vld, s_ts_now, s_ts, s_pol,
    output s_rdy, m_vld, m_mag, m_pol
  );

  modport master (
    output s_vld, s_ts_now, s_ts, s_pol,
    input  s_rdy, m_vld, m_mag, m_pol
  );
endinterface

// File: rtl/age_quant.sv
// One lane of age quantization (purely combinational).
//   ts_now, ts_pix : event timestamp and the pixel's last timestamp
//   pol_in         : stored polarity of the pixel
//   mag, pol_out   : quantized age magnitude and gated polarity
// Younger pixels get larger magnitudes; invalid polarities silence the lane.
module age_quant
  import dnd_pkg::*;
#(
  parameter int W_X   = dnd_pkg::W_X,
  parameter int W_T   = dnd_pkg::W_T,
  parameter int SHIFT = dnd_pkg::SHIFT
) (
  input  logic [W_T-1:0] ts_now,
  input  logic [W_T-1:0] ts_pix,
  input  logic [1:0]     pol_in,
  output logic [W_X-1:0] mag,
  output logic [1:0]     pol_out
);
  localparam logic [W_T-1:0] MAG_MAX = W_T'((1 << W_X) - 1);

  logic [W_T-1:0] dt_s;
  logic [W_T-1:0] q_s;

  // Modular subtraction keeps ages correct across timestamp wrap.
  assign dt_s = ts_now - ts_pix;
  assign q_s  = dt_s >> SHIFT;

  // Saturating inversion of the age plus polarity gating (10 counts as none).
  always_comb begin
    mag     = '0;
    pol_out = POL_NONE;
    if ((pol_in == POL_ON) || (pol_in == POL_OFF)) begin
      pol_out = pol_in;
      if (q_s < MAG_MAX) begin
        mag = W_X'(MAG_MAX - q_s);
      end else begin
        mag = '0;
      end
    end else begin
      mag     = '0;
      pol_out = POL_NONE;
    end
  end
endmodule

// File: rtl/patch_serializer.sv
// Patch serializer: captures one pixel patch on the s_vld/s_rdy handshake and
// streams it as N_BEATS beats of P lanes (age magnitude + polarity), one beat
// per clock, then idles MIN_GAP cycles before accepting the next patch.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : patch_serializer_if slave modport (handshake, patch data, beats)
module patch_serializer
  import dnd_pkg::*;
#(
  parameter int N_PIX   = dnd_pkg::N_PIX,
  parameter int P       = dnd_pkg::P,
  parameter int W_X     = dnd_pkg::W_X,
  parameter int W_T     = dnd_pkg::W_T,
  parameter int SHIFT   = dnd_pkg::SHIFT,
  parameter int MIN_GAP = dnd_pkg::MIN_GAP
) (
  input  logic               clk,
  input  logic               rst,
  patch_serializer_if.slave  bus
);
  localparam int N_BEATS = (N_PIX + P - 1) / P;
  localparam int N_SLOT  = N_BEATS * P;   // pixel slots including zero padding
  localparam int BEAT_W  = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;
  localparam int SLOT_W  = (N_SLOT > 1) ? $clog2(N_SLOT) : 1;
  localparam int GAP_W   = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(N_BEATS - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((MIN_GAP > 0) ? (MIN_GAP - 1) : 0);

  ser_state_e        state_r;
  logic [BEAT_W-1:0] beat_r;
  logic [GAP_W-1:0]  gap_r;
  logic [W_T-1:0]    ts_now_r;
  logic [W_T-1:0]    ts_r   [N_SLOT];
  logic [1:0]        pol_r  [N_SLOT];
  logic [W_T-1:0]    ts_in_s  [N_SLOT];
  logic [1:0]        pol_in_s [N_SLOT];
  logic [W_T-1:0]    lane_ts_s   [P];
  logic [1:0]        lane_pol_s  [P];
  logic [W_X-1:0]    lane_mag_s  [P];
  logic [1:0]        lane_polo_s [P];
  logic              handshake_s;
  logic              m_vld_r;
  logic [P*W_X-1:0]  m_mag_r;
  logic [P*2-1:0]    m_pol_r;

  assign bus.s_rdy  = (state_r == ST_IDLE) && !rst;
  assign handshake_s = bus.s_vld && bus.s_rdy;
  assign bus.m_vld  = m_vld_r;
  assign bus.m_mag  = m_mag_r;
  assign bus.m_pol  = m_pol_r;

  // Unpack the flat patch buses; slots past N_PIX read as "no event" so the
  // tail lanes of the last beat come out zero.
  always_comb begin
    for (int i = 0; i < N_SLOT; i++) begin
      ts_in_s[i]  = '0;
      pol_in_s[i] = POL_NONE;
    end
    for (int i = 0; i < N_PIX; i++) begin
      ts_in_s[i]  = bus.s_ts[i*W_T +: W_T];
      pol_in_s[i] = bus.s_pol[i*2 +: 2];
    end
  end

  // Pick pixels beat*P+p for the lanes of the current beat.
  always_comb begin
    for (int p = 0; p < P; p++) begin
      lane_ts_s[p]  = ts_r[SLOT_W'(beat_r) * SLOT_W'(P) + SLOT_W'(p)];
      lane_pol_s[p] = pol_r[SLOT_W'(beat_r) * SLOT_W'(P) + SLOT_W'(p)];
    end
  end

  for (genvar p = 0; p < P; p++) begin : g_lane
    age_quant #(
      .W_X   (W_X),
      .W_T   (W_T),
      .SHIFT (SHIFT)
    ) u_age_quant (
      .ts_now  (ts_now_r),
      .ts_pix  (lane_ts_s[p]),
      .pol_in  (lane_pol_s[p]),
      .mag     (lane_mag_s[p]),
      .pol_out (lane_polo_s[p])
    );
  end

  // Patch capture; only a handshake (impossible in reset) loads new data.
  always_ff @(posedge clk) begin
    if (rst) begin
      ts_now_r <= '0;
      for (int i = 0; i < N_SLOT; i++) begin
        ts_r[i]  <= '0;
        pol_r[i] <= POL_NONE;
      end
    end else if (handshake_s) begin
      ts_now_r <= bus.s_ts_now;
      for (int i = 0; i < N_SLOT; i++) begin
        ts_r[i]  <= ts_in_s[i];
        pol_r[i] <= pol_in_s[i];
      end
    end
  end

  // Control FSM with beat/gap counters and registered beat outputs; outputs
  // default to zero so they are only non-zero while streaming.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      beat_r  <= '0;
      gap_r   <= '0;
      m_vld_r <= 1'b0;
      m_mag_r <= '0;
      m_pol_r <= '0;
    end else begin
      m_vld_r <= 1'b0;
      m_mag_r <= '0;
      m_pol_r <= '0;
      case (state_r)
        ST_IDLE: begin
          if (handshake_s) begin
            state_r <= ST_STREAM;
            beat_r  <= '0;
          end
        end
        ST_STREAM: begin
          m_vld_r <= 1'b1;
          for (int p = 0; p < P; p++) begin
            m_mag_r[p*W_X +: W_X] <= lane_mag_s[p];
            m_pol_r[p*2 +: 2]     <= lane_polo_s[p];
          end
          if (beat_r == BEAT_LAST) begin
            beat_r  <= '0;
            gap_r   <= '0;
            state_r <= (MIN_GAP == 0) ? ST_IDLE : ST_HOLD;
          end else begin
            beat_r <= beat_r + BEAT_W'(1);
          end
        end
        ST_HOLD: begin
          if (gap_r == GAP_LAST) begin
            state_r <= ST_IDLE;
          end else begin
            gap_r <= gap_r + GAP_W'(1);
          end
        end
        default: begin
          state_r <= ST_IDLE;
          beat_r  <= '0;
          gap_r   <= '0;
        end
      endcase
    end
  end
endmodule
